// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_rr_arbiter
// Description : Round-robin arbiter sharing one single-port SRAM (1-cycle read
//               latency) between NumReq requesters, with a freeze/drain
//               handshake. Optional macro SRAM_ARB_LOCK_EN adds req_lock_i.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arbiter #(
  parameter int NumReq    = 2,
  parameter int Depth     = 16,
  parameter int DataWidth = 8,
  parameter int ByteWidth = 8,
  parameter int AddrWidth = $clog2(Depth),
  parameter int BeWidth   = DataWidth / ByteWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0]              req_we_i,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq*BeWidth-1:0]      req_be_i,
  input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
`ifdef SRAM_ARB_LOCK_EN
  input  logic [NumReq-1:0]              req_lock_i,
`endif
  output logic [NumReq-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  input  logic                           freeze_i,
  output logic                           frozen_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [AddrWidth-1:0]           sram_addr_o,
  output logic [BeWidth-1:0]             sram_be_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  input  logic [DataWidth-1:0]           sram_rdata_i
);

  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IdxWidth-1:0] ptr_q, ptr_next;
  logic                pend_q;
  logic [IdxWidth-1:0] pend_id_q;
  logic                arb_en;
  logic                found;
  logic [IdxWidth-1:0] gnt_idx;
  logic [IdxWidth-1:0] cand;
`ifdef SRAM_ARB_LOCK_EN
  logic                lock_q;
  logic [IdxWidth-1:0] lock_id_q;
`endif

  // Grants are held off during reset and in the same cycle a freeze is requested.
  assign arb_en = rst_ni && (state_q == ST_RUN) && !freeze_i;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (arb_en) begin
`ifdef SRAM_ARB_LOCK_EN
      if (lock_q) begin
        found   = req_valid_i[lock_id_q];
        gnt_idx = lock_id_q;
      end else begin
`endif
        for (int k = 0; k < NumReq; k++) begin
          cand = IdxWidth'((int'(ptr_q) + k) % NumReq);
          if (!found && req_valid_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
          end
        end
`ifdef SRAM_ARB_LOCK_EN
      end
`endif
    end
  end

  assign ptr_next = IdxWidth'((int'(gnt_idx) + 1) % NumReq);

  always_comb begin
    req_ready_o = '0;
    if (found) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    if (found) begin
      sram_we_o    = req_we_i[gnt_idx];
      sram_addr_o  = req_addr_i[int'(gnt_idx)*AddrWidth +: AddrWidth];
      sram_be_o    = req_be_i[int'(gnt_idx)*BeWidth +: BeWidth];
      sram_wdata_o = req_wdata_i[int'(gnt_idx)*DataWidth +: DataWidth];
    end
  end

  assign sram_req_o = found;

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (pend_q) begin
      rsp_valid_o[pend_id_q] = 1'b1;
      rsp_rdata_o            = sram_rdata_i;
    end
  end

  // Idle as soon as the last in-flight response has been delivered.
  assign frozen_o = (state_q != ST_RUN) && !pend_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (freeze_i) state_d = ST_DRAIN;
      ST_DRAIN:  if (!freeze_i) state_d = ST_RUN;
                 else if (!pend_q) state_d = ST_FROZEN;
      ST_FROZEN: if (!freeze_i) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      ptr_q     <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
`ifdef SRAM_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= found && !req_we_i[gnt_idx];
      pend_id_q <= gnt_idx;
`ifdef SRAM_ARB_LOCK_EN
      if (found) begin
        if (req_lock_i[gnt_idx]) begin
          lock_q    <= 1'b1;
          lock_id_q <= gnt_idx;
        end else begin
          lock_q    <= 1'b0;
          ptr_q     <= ptr_next;
        end
      end else if (freeze_i) begin
        lock_q <= 1'b0;
      end
`else
      if (found) ptr_q <= ptr_next;
`endif
    end
  end

`ifndef SYNTHESIS
  a_onehot_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_ready_o & ~req_valid_i) == '0);
  a_grant_only_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != ST_RUN) |-> (req_ready_o == '0));
  a_frozen_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    frozen_o |-> !pend_q);
  for (genvar i = 0; i < NumReq; i++) begin : g_hold
    a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[i] && !req_ready_o[i]) |=> req_valid_i[i]);
  end
`endif

endmodule
`default_nettype wire
